fifo_wr_arbiter: RTL and testbench

//  Write-side controller for the async FIFO memory. Shares the single memory write port between N_REQ requesters.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write side: pointer width, Gray encoding
// and the grant index type used inside the requester arbiter.
package fifo_pkg;

    localparam int GID_MAX_W = 8;

    typedef logic [GID_MAX_W-1:0] gid_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin pick among N_REQ requests, search starts after (or at, when holding) last.
// Latency: purely combinational, grant valid in the same cycle as the requests.
// Backpressure: none of its own; the caller masks the grant when the FIFO is full.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic             hold,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    always_comb begin
        gid_t start;
        gid_t cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        start = hold ? gid_t'(last) : gid_t'(last) + gid_t'(1);
        if (start >= gid_t'(N_REQ))
            start = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = start + gid_t'(k);
            if (cand >= gid_t'(N_REQ))
                cand = cand - gid_t'(N_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found               = 1'b1;
                gnt[cand[IW-1:0]]   = 1'b1;
                idx                 = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Async FIFO write side: shares the memory write port among N_REQ requesters, owns wbin/wptr/wfull.
// Latency: zero, the granted word is written on the wclk edge that accepts it; wfull is registered.
// Backpressure: at most one req_ready per cycle, all forced low while wfull. FIFO_WR_BURST_EN adds burst hold.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int BURST  = 4,
    localparam int ADDR  = ptr_w(DEPTH),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [ADDR:0]          wq2_rptr,
    output logic                   wen,
    output logic [ADDR-1:0]        waddr,
    output logic [WIDTH-1:0]       wdata,
    output logic [ADDR:0]          wptr,
    output logic                   wfull,
    output logic [IW-1:0]          grant_id
);

`ifdef FIFO_WR_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int PW  = ADDR + 1;
    localparam int BCW = $clog2(BURST + 1);
    localparam logic [BCW-1:0] BURST_V = BCW'(BURST);

    logic [ADDR:0]    wbin;
    logic [ADDR:0]    wbin_nxt;
    logic [ADDR:0]    gnext;
    logic [ADDR:0]    full_cmp;
    logic [IW-1:0]    last;
    logic [IW-1:0]    win;
    logic [N_REQ-1:0] gnt;
    logic [BCW-1:0]   bcnt;
    logic [BCW-1:0]   bcnt_inc;
    logic             hold;
    logic             accept;

    // bcnt stays zero without burst mode, so hold is never raised
    assign hold     = BURST_EN && (bcnt != '0) && (bcnt < BURST_V) && req_valid[last];
    assign bcnt_inc = hold ? bcnt + BCW'(1) : BCW'(1);

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req  (req_valid),
        .last (last),
        .hold (hold),
        .gnt  (gnt),
        .idx  (win)
    );

    assign req_ready = gnt & {N_REQ{~wfull}};
    assign accept    = |(req_valid & req_ready);
    assign wen       = accept;
    assign wdata     = req_data[win*WIDTH +: WIDTH];
    assign grant_id  = win;
    assign waddr     = wbin[ADDR-1:0];

    assign wbin_nxt = wbin + {{ADDR{1'b0}}, accept};
    assign gnext    = PW'(bin2gray(32'(wbin_nxt)));
    // Full when the next Gray pointer is a whole lap ahead of the synchronized read pointer
    assign full_cmp = {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            last  <= IW'(N_REQ - 1);
            bcnt  <= '0;
        end else begin
            wbin  <= wbin_nxt;
            wptr  <= gnext;
            wfull <= (gnext == full_cmp);
            if (accept)
                last <= win;
            if (BURST_EN) begin
                if (accept)
                    bcnt <= (bcnt_inc == BURST_V) ? '0 : bcnt_inc;
                else if (!req_valid[last])
                    bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expectations queued per driven cycle, checked at negedge.
module tb_fifo_wr_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int BURST = 4;
    localparam int ADDR  = 4;
    localparam int IW    = 2;

    logic                   wclk = 1'b0;
    logic                   wrst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [ADDR:0]          wq2_rptr;
    logic                   wen;
    logic [ADDR-1:0]        waddr;
    logic [WIDTH-1:0]       wdata;
    logic [ADDR:0]          wptr;
    logic                   wfull;
    logic [IW-1:0]          grant_id;

    fifo_wr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wq2_rptr  (wq2_rptr),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wptr      (wptr),
        .wfull     (wfull),
        .grant_id  (grant_id)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic          wen;
        int            gid;
        logic [ADDR:0] bin;
        logic          full;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [ADDR:0] m_wbin;
    logic [ADDR:0] rbin;
    logic          m_full;

    function automatic logic [ADDR:0] gray(input logic [ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] dat(input int i, input int c);
        return WIDTH'(i * 64 + (c % 64));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1
    task automatic cycle(input string tag, input logic [N_REQ-1:0] v, input int gid);
        exp_t          e;
        exp_t          p;
        logic [ADDR:0] occ;
        e.wen  = (v != '0) && !m_full;
        e.gid  = gid;
        e.bin  = m_wbin;
        e.full = m_full;
        sb.push_back(e);
        req_valid = v;
        wq2_rptr  = gray(rbin);
        for (int i = 0; i < N_REQ; i++)
            req_data[i*WIDTH +: WIDTH] = dat(i, cyc);
        @(negedge wclk);
        p = sb.pop_front();
        chk({tag, "_wen"},  32'(wen),       32'(p.wen));
        chk({tag, "_full"}, 32'(wfull),     32'(p.full));
        chk({tag, "_wptr"}, 32'(wptr),      32'(gray(p.bin)));
        chk({tag, "_rdy"},  32'(req_ready), p.wen ? (32'd1 << p.gid) : 32'd0);
        if (p.wen) begin
            chk({tag, "_gid"},   32'(grant_id), 32'(p.gid));
            chk({tag, "_waddr"}, 32'(waddr),    32'(p.bin[ADDR-1:0]));
            chk({tag, "_wdata"}, 32'(wdata),    32'(dat(p.gid, cyc)));
        end
        @(posedge wclk);
        if (p.wen)
            m_wbin = m_wbin + 1'b1;
        occ    = m_wbin - rbin;
        m_full = (occ == (ADDR+1)'(DEPTH));
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        wrst_n    = 1'b0;
        @(posedge wclk);
        #1;
        wrst_n   = 1'b1;
        m_wbin   = '0;
        m_full   = 1'b0;
        rbin     = '0;
        wq2_rptr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        wq2_rptr  = '0;
        rbin      = '0;
        m_wbin    = '0;
        m_full    = 1'b0;
        #1 wrst_n = 1'b0;
        #2;
        chk("rst_wptr",  32'(wptr),      32'd0);
        chk("rst_full",  32'(wfull),     32'd0);
        chk("rst_wen",   32'(wen),       32'd0);
        chk("rst_rdy",   32'(req_ready), 32'd0);
        chk("rst_waddr", 32'(waddr),     32'd0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;

        // Fill from requester 0 alone, then the 17th request must be refused
        for (int k = 0; k < 16; k++)
            cycle("t1", 4'b0001, 0);
        cycle("t1_full", 4'b0001, 0);

        // Read side frees one slot: full drops one edge later, one write, full again
        rbin = 1;
        cycle("t4_adv", 4'b0000, 0);
        cycle("t4_wr", 4'b0001, 0);
        cycle("t4_refull", 4'b0001, 0);
        rbin = m_wbin;
        cycle("drain", 4'b0000, 0);

`ifdef FIFO_WR_BURST_EN
        do_reset();
        for (int k = 0; k < 4; k++)
            cycle("t5_b0", 4'b0011, 0);
        for (int k = 0; k < 4; k++)
            cycle("t5_b1", 4'b0011, 1);
        cycle("t5_back0", 4'b0011, 0);
        cycle("t5_hold0", 4'b0011, 0);
        cycle("t5_drop0", 4'b0010, 1);
`else
        // Last grant was 0, so rotation continues from 1
        for (int k = 0; k < 8; k++)
            cycle("t2_rr", 4'b1111, (k + 1) % 4);
        for (int k = 0; k < 4; k++)
            cycle("t3_alt", 4'b0101, (k % 2 == 0) ? 2 : 0);
        for (int k = 0; k < 3; k++)
            cycle("t3_drop", 4'b0001, 0);
`endif

        // Asynchronous reset in the middle of a stream with wbin=9
        do_reset();
        for (int k = 0; k < 9; k++)
            cycle("t6_pre", 4'b0001, 0);
        req_valid = '0;
        #1;
        chk("t6_pre_wptr", 32'(wptr), 32'(gray(5'd9)));
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_wptr",  32'(wptr),  32'd0);
        chk("t6_rst_full",  32'(wfull), 32'd0);
        chk("t6_rst_wen",   32'(wen),   32'd0);
        chk("t6_rst_waddr", 32'(waddr), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        m_wbin = '0;
        m_full = 1'b0;
        rbin   = '0;
        cycle("t6_after", 4'b1001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
